// File: rtl/avr_prog_loader_pkg.sv
// Shared definitions for the program-memory loader: FSM state encoding,
// error codes and a small state classification helper.
package avr_prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA_LO,
        DATA_HI,
        CSUM,
        DONE,
        ERR
    } ldr_state_t;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_LEN  = 2'b01;
    localparam logic [1:0] ERR_CSUM = 2'b10;

    // Busy states are exactly the ones that consume stream bytes.
    function automatic logic is_busy(input ldr_state_t s);
        return (s != IDLE) && (s != DONE) && (s != ERR);
    endfunction

endpackage

// File: rtl/avr_loader_csum.sv
// 8-bit running checksum: clear, accumulate, and a zero test that
// includes the byte currently presented on din.
module avr_loader_csum
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       clr,
    input  logic       acc,
    input  logic [7:0] din,
    output logic       zero
);

    logic [7:0] sum;

    always_ff @(posedge CLK) begin
        if (RST || clr)
            sum <= 8'h00;
        else if (acc)
            sum <= sum + din;
    end

    assign zero = (8'(sum + din) == 8'h00);

endmodule

// File: rtl/avr_prog_loader.sv
// Byte-stream program loader: assembles 16-bit words, writes program RAM,
// stalls the CPU during the load and validates length and checksum.
module avr_prog_loader
    import avr_prog_loader_pkg::*;
#(
    parameter int ADDR_W    = 9,
    parameter int BASE_ADDR = 0
)
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              wr_en,
    output logic              cpu_hold,
    output logic              done,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [16:0] MAX_LEN = 17'((1 << ADDR_W) - BASE_ADDR);

    ldr_state_t      state;
    logic [7:0]      len_lo;
    logic [7:0]      lo_byte;
    logic [ADDR_W:0] len;
    logic [ADDR_W:0] rx_cnt;
    logic [ADDR_W:0] rx_next;
    logic [15:0]     n;
    logic            xfer;
    logic            accept_start;
    logic            csum_zero;

    assign byte_ready   = is_busy(state);
    assign xfer         = byte_valid && byte_ready;
    assign accept_start = start && !is_busy(state);
    assign n            = {byte_in, len_lo};
    assign rx_next      = rx_cnt + 1'b1;

    avr_loader_csum u_csum (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (accept_start),
        .acc  (xfer && (state == DATA_LO || state == DATA_HI)),
        .din  (byte_in),
        .zero (csum_zero)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            len_lo       <= 8'h00;
            lo_byte      <= 8'h00;
            len          <= '0;
            rx_cnt       <= '0;
            wr_addr      <= '0;
            wr_data      <= 16'h0000;
            wr_en        <= 1'b0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            err_code     <= ERR_NONE;
            words_loaded <= '0;
        end else begin
            wr_en <= 1'b0;
            // Address advances in the strobe cycle so the write sees the old value.
            if (wr_en) begin
                wr_addr      <= wr_addr + 1'b1;
                words_loaded <= words_loaded + 1'b1;
            end
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= LEN_LO;
                        done         <= 1'b0;
                        err_code     <= ERR_NONE;
                        words_loaded <= '0;
                        rx_cnt       <= '0;
                        wr_addr      <= ADDR_W'(BASE_ADDR);
                        cpu_hold     <= 1'b1;
                    end
                end
                LEN_LO: if (xfer) begin
                    len_lo <= byte_in;
                    state  <= LEN_HI;
                end
                LEN_HI: if (xfer) begin
                    if ({1'b0, n} > MAX_LEN) begin
                        state    <= ERR;
                        err_code <= ERR_LEN;
                        cpu_hold <= 1'b0;
                    end else begin
                        len   <= n[ADDR_W:0];
                        state <= (n == 16'h0000) ? CSUM : DATA_LO;
                    end
                end
                DATA_LO: if (xfer) begin
                    lo_byte <= byte_in;
                    state   <= DATA_HI;
                end
                DATA_HI: if (xfer) begin
                    wr_data <= {byte_in, lo_byte};
                    wr_en   <= 1'b1;
                    rx_cnt  <= rx_next;
                    state   <= (rx_next == len) ? CSUM : DATA_LO;
                end
                CSUM: if (xfer) begin
                    cpu_hold <= 1'b0;
                    if (csum_zero) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state    <= ERR;
                        err_code <= ERR_CSUM;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_avr_prog_loader.sv
// Bench for avr_prog_loader: table vectors, boundary and reset sequences,
// and random loads checked against a stream-level reference model.
module tb_avr_prog_loader;
    import avr_prog_loader_pkg::*;

    localparam int AW   = 9;
    localparam int BASE = 0;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    typedef struct {
        logic [95:0] raw;
        int          nb;
        int          mode;
        bit          e_done;
        logic [1:0]  e_err;
        int          e_words;
        int          e_nwr;
        int          e_cons;
    } vec_t;

    logic          CLK, RST, start, byte_valid, byte_ready, wr_en, cpu_hold, done;
    logic [7:0]    byte_in;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [1:0]    err_code;
    logic [AW:0]   words_loaded;

    int  n_pass = 0;
    int  n_tot  = 0;
    wq_t wlog;

    avr_prog_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
        .CLK(CLK), .RST(RST), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_en(wr_en), .cpu_hold(cpu_hold), .done(done),
        .err_code(err_code), .words_loaded(words_loaded)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Every strobe cycle is logged with the hold level seen during it.
    always @(negedge CLK)
        if (wr_en === 1'b1) wlog.push_back({cpu_hold, 6'd0, wr_addr, wr_data});

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference: interpret the stream directly.
    task automatic model(input bq_t s, output wq_t w, output bit d, output logic [1:0] e, output int nw);
        int n;
        int sum;
        n = int'(s[0]) + 256 * int'(s[1]);
        sum = 0;
        w.delete(); d = 0; e = ERR_NONE; nw = 0;
        if (n > (1 << AW) - BASE) begin
            e = ERR_LEN;
            return;
        end
        for (int i = 0; i < n; i++) begin
            w.push_back({1'b1, 6'd0, 9'(BASE + i), s[3 + 2*i], s[2 + 2*i]});
            sum += int'(s[2 + 2*i]) + int'(s[3 + 2*i]);
        end
        nw = n;
        if ((sum + int'(s[2 + 2*n])) % 256 == 0) d = 1;
        else e = ERR_CSUM;
    endtask

    task automatic build(input int n, input bit good, output bq_t s);
        int   sum;
        logic [7:0] b, c;
        sum = 0;
        s.delete();
        s.push_back(n[7:0]);
        s.push_back(n[15:8]);
        if (n > (1 << AW) - BASE) begin
            repeat (3) s.push_back(8'($urandom));
            return;
        end
        for (int i = 0; i < 2*n; i++) begin
            b = 8'($urandom);
            sum += int'(b);
            s.push_back(b);
        end
        c = 8'((256 - sum % 256) % 256);
        if (!good) c = c ^ 8'($urandom_range(1, 255));
        s.push_back(c);
    endtask

    // mode 0: valid every cycle, 1: 1-0-0 pattern plus a mid-load start, 2: random valid
    task automatic do_load(input string tag, input bq_t s, input int mode, output int cons);
        int idx, cyc, pat;
        bit fin, prev_hold, v;
        idx = 0; cyc = 0; pat = 0; fin = 0; prev_hold = 0;
        wlog.delete();
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        while (!fin && cyc < 5000) begin
            if (done === 1'b1 || err_code !== ERR_NONE) begin
                fin = 1;
                chk({tag, " hold_edge"}, {62'd0, prev_hold, cpu_hold}, 64'd2);
            end else begin
                prev_hold = cpu_hold;
                v = (mode == 0) ? 1'b1 : (mode == 1) ? (pat % 3 == 0) : 1'($urandom_range(0, 1));
                pat++;
                start = (mode == 1 && cyc == 10);
                if (v && idx < s.size()) begin
                    byte_valid = 1'b1;
                    byte_in    = s[idx];
                    if (byte_ready === 1'b1) idx++;
                end else begin
                    byte_valid = 1'b0;
                    byte_in    = 8'($urandom);
                end
                @(negedge CLK);
                cyc++;
            end
        end
        byte_valid = 1'b0;
        start      = 1'b0;
        chk({tag, " finished"}, 64'(fin), 64'd1);
        cons = idx;
    endtask

    task automatic check_load(input string tag, input bq_t s);
        wq_t ew;
        bit ed;
        logic [1:0] ee;
        int enw, bad;
        bad = 0;
        model(s, ew, ed, ee, enw);
        chk({tag, " nwr"}, 64'(wlog.size()), 64'(ew.size()));
        for (int i = 0; i < ew.size() && i < wlog.size(); i++)
            if (wlog[i] !== ew[i]) bad++;
        chk({tag, " wr_bad"}, 64'(bad), 64'd0);
        chk({tag, " done"}, 64'(done), 64'(ed));
        chk({tag, " err"}, 64'(err_code), 64'(ee));
        chk({tag, " words"}, 64'(words_loaded), 64'(enw));
        chk({tag, " idle_outs"}, {62'd0, cpu_hold, byte_ready}, 64'd0);
    endtask

    initial begin
        vec_t tv[5];
        bq_t  s;
        int   cons;
        string tag;

        tv[0] = '{96'h03000C943412FFCF4C000000, 9, 0, 1'b1, ERR_NONE, 3, 3, 9};
        tv[1] = '{96'h03000C943412FFCF4D000000, 9, 0, 1'b0, ERR_CSUM, 3, 3, 9};
        tv[2] = '{96'h0102AA000000000000000000, 3, 0, 1'b0, ERR_LEN,  0, 0, 2};
        tv[3] = '{96'h000000000000000000000000, 3, 0, 1'b1, ERR_NONE, 0, 0, 3};
        tv[4] = '{96'h03000C943412FFCF4C000000, 9, 1, 1'b1, ERR_NONE, 3, 3, 9};

        RST = 1'b1; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
        repeat (3) @(negedge CLK);
        chk("reset outs", {23'd0, byte_ready, wr_en, cpu_hold, done, err_code, wr_addr, wr_data, words_loaded}, 64'd0);
        RST = 1'b0;

        for (int k = 0; k < 5; k++) begin
            tag = $sformatf("vec%0d", k);
            s.delete();
            for (int i = 0; i < tv[k].nb; i++) s.push_back(tv[k].raw[95 - 8*i -: 8]);
            do_load(tag, s, tv[k].mode, cons);
            check_load(tag, s);
            chk({tag, " tbl_done"}, 64'(done), 64'(tv[k].e_done));
            chk({tag, " tbl_err"}, 64'(err_code), 64'(tv[k].e_err));
            chk({tag, " tbl_words"}, 64'(words_loaded), 64'(tv[k].e_words));
            chk({tag, " tbl_nwr"}, 64'(wlog.size()), 64'(tv[k].e_nwr));
            chk({tag, " tbl_cons"}, 64'(cons), 64'(tv[k].e_cons));
        end

        // Largest legal image: last write lands on the top word.
        build((1 << AW) - BASE, 1'b1, s);
        do_load("full", s, 0, cons);
        check_load("full", s);

        for (int r = 0; r < 10; r++) begin
            int n;
            bit good;
            n = (r == 3) ? 513 + int'($urandom_range(0, 3000)) : int'($urandom_range(0, 20));
            good = ($urandom_range(0, 3) != 0);
            build(n, good, s);
            tag = $sformatf("rnd%0d", r);
            do_load(tag, s, 2, cons);
            check_load(tag, s);
        end

        // Reset right after the second word's hi byte, during its write strobe.
        wlog.delete();
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            byte_valid = 1'b1;
            byte_in    = tv[0].raw[95 - 8*i -: 8];
            @(negedge CLK);
        end
        byte_valid = 1'b0;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("rst_mid outs", {23'd0, byte_ready, wr_en, cpu_hold, done, err_code, wr_addr, wr_data, words_loaded}, 64'd0);
        chk("rst_mid nwr", 64'(wlog.size()), 64'd2);
        if (wlog.size() >= 2) begin
            chk("rst_mid w0", 64'(wlog[0]), 64'h8000_940C);
            chk("rst_mid w1", 64'(wlog[1]), 64'h8001_1234);
        end

        s.delete();
        for (int i = 0; i < 9; i++) s.push_back(tv[0].raw[95 - 8*i -: 8]);
        do_load("reload", s, 0, cons);
        check_load("reload", s);
        chk("reload done", 64'(done), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/avr_prog_loader.md
Name: avr_prog_loader

Overview:
- Writer side of the program-memory interface. Accepts a byte stream (host or UART front end), assembles 16-bit instruction words, and writes them into a writable program RAM that the fetch unit later reads.
- Holds the CPU in stall while a load is in progress.
- Validates the image length and an 8-bit checksum, then reports done or error.

Parameters:
- ADDR_W, 9, program word-address width; memory depth is 2^ADDR_W words.
- BASE_ADDR, 0, word address where the first loaded word is written.

Ports:
- CLK  in  1  clock
- RST  in  1  reset, synchronous, active-high
- start  in  1  begin a load; sampled in IDLE, DONE or ERR only
- byte_in  in  8  stream data byte
- byte_valid  in  1  byte_in is valid
- byte_ready  out  1  loader accepts a byte this cycle
- wr_addr  out  ADDR_W  program RAM word address
- wr_data  out  16  instruction word, {hi_byte, lo_byte}; written as the CPU consumes it, no byte swap
- wr_en  out  1  single-cycle program RAM write strobe
- cpu_hold  out  1  stall request to CPU/fetch
- done  out  1  load completed with good checksum (level)
- err_code  out  2  00 none, 01 length overflow, 10 checksum mismatch (level)
- words_loaded  out  ADDR_W+1  count of words written in the current/last load

Behaviour:
- Stream format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 2N data bytes (low byte first per word), then CSUM.
- Checksum rule: (sum of all 2N data bytes + CSUM) mod 256 == 0. Length bytes are not summed.
- Byte transfer occurs on any cycle with byte_valid && byte_ready.
- byte_ready = 1 only in LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM.
- Reset: state IDLE; all outputs 0 (byte_ready, wr_en, cpu_hold, done, err_code, wr_addr, wr_data, words_loaded); internal sum and count cleared.
- FSM:
  - IDLE/DONE/ERR --start--> LEN_LO. Clears done, err_code, sum, words_loaded; wr_addr := BASE_ADDR.
  - LEN_LO --xfer--> LEN_HI.
  - LEN_HI --xfer--> if N > 2^ADDR_W - BASE_ADDR: ERR (err_code=01). Else if N == 0: CSUM. Else: DATA_LO.
  - DATA_LO --xfer--> DATA_HI (latch lo byte, add to sum).
  - DATA_HI --xfer--> add hi byte to sum. Register wr_data={hi,lo} and pulse wr_en the following cycle at current wr_addr. Then increment wr_addr and words_loaded. Next state: DATA_LO if more words remain, else CSUM.
  - CSUM --xfer--> if (sum+byte)[7:0]==0: DONE (done=1), else ERR (err_code=10).
- Write latency: wr_en is high exactly 1 cycle, in the cycle after the hi-byte handshake. wr_addr/wr_data are stable during that cycle.
- cpu_hold: 1 from the cycle after start is accepted until the cycle DONE/ERR is entered (deasserts in the same cycle done/err_code rises). It must cover the final wr_en pulse.
- start while busy (LEN_LO..CSUM) is ignored.
- byte_valid while byte_ready=0 has no effect; the byte is not consumed.
- Stalls: byte_valid low for any number of cycles pauses the FSM with no timeout.
- wr_addr does not wrap; the length check guarantees the last write is at BASE_ADDR+N-1 ≤ 2^ADDR_W-1.
- RST mid-load: return to IDLE next edge, wr_en 0, cpu_hold 0. Words already written remain in RAM.
- ERR on checksum: earlier words were already written. It is the host's responsibility to reload.

Decomposition:
- Shared package: state encoding (IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CSUM, DONE, ERR) and err_code constants (ERR_NONE, ERR_LEN, ERR_CSUM). These are reused by the program RAM write-port wrapper and the bench.
- One sub-module: avr_loader_csum (8-bit running sum with clear/accumulate and zero-check), reused by a future data-memory loader.

Test Plan:
- Good load of 3 words: stream 03 00 0C 94 34 12 FF CF 4C, byte_valid always 1.
  - Required: writes (0,0x940C), (1,0x1234), (2,0xCFFF), one wr_en cycle each.
  - Then done=1, err_code=00, words_loaded=3, cpu_hold falls with done.
- Same stream but CSUM=4D:
  - Required: three writes still occur, then err_code=10, done=0, cpu_hold=0.
- Length overflow (ADDR_W=9, BASE_ADDR=0): LEN 01 02 (N=513).
  - Required: ERR after LEN_HI, err_code=01, no wr_en, byte_ready=0 afterwards.
- Zero length: stream 00 00 00.
  - Required: done=1, words_loaded=0, no wr_en.
- Throttled stream: good 3-word load with byte_valid toggling 1-0-0 per byte; assert start mid-load.
  - Required: identical writes and result to the first scenario; the mid-load start is ignored.
- Reset mid-load: assert RST after the 2nd data word's hi byte.
  - Required: next cycle IDLE, all outputs 0; RAM words 0,1 retain 0x940C, 0x1234.
  - A subsequent start plus a full good stream completes with done=1.
